// File: rtl/cpu_pkg.sv
// Shared CPU encodings for the writeback path.
// Holds the wdsel/ldtype enums and the M->W bundle struct.
package cpu_pkg;

  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC8 = 2'd2,
    WD_RSV = 2'd3
  } wdsel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ldtype_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  wdsel;
    logic [2:0]  ldtype;
    logic [1:0]  addr;
    logic [31:0] alu;
    logic [31:0] mem;
  } m_w_t;

  function automatic logic [31:0] pc_plus8(
    input logic [31:0] pc
  );
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Little-endian load extraction and sign/zero extension.
// Ports: ldtype_i, addr_i[1:0], word_i in; data_o out (comb).
module wb_load_ext
  import cpu_pkg::*;
(
  input  logic [2:0]  ldtype_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] sh_b;
  logic [31:0] sh_h;
  logic [7:0]  b;
  logic [15:0] h;

  assign sh_b = word_i >> {addr_i, 3'b000};
  assign sh_h = word_i >> {addr_i[1], 4'b0000};
  assign b    = sh_b[7:0];
  assign h    = sh_h[15:0];

  always_comb begin
    data_o = word_i;
    case (ldtype_e'(ldtype_i))
      LD_LB:   data_o = {{24{b[7]}}, b};
      LD_LBU:  data_o = {24'd0, b};
      LD_LH:   data_o = {{16{h[15]}}, h};
      LD_LHU:  data_o = {16'd0, h};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/grf_wb_driver.sv
// W-stage register and GRF write port driver with retire counter.
// In: M-stage fields, stall/flush, clk, sync rstn (active low).
// Out: A3/WD3/we3/npc to the GRF, retire_cnt.
// Macro GRF_WB_TRACE_EN enables a per-write trace print.
module grf_wb_driver
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             WB_clk_W_i,
  input  logic             WB_rstn_W_i,
  input  logic             WB_valid_M_i,
  input  logic [31:0]      WB_pc_M_i,
  input  logic [4:0]       WB_rd_M_i,
  input  logic             WB_regwrite_M_i,
  input  logic [1:0]       WB_wdsel_M_i,
  input  logic [2:0]       WB_ldtype_M_i,
  input  logic [31:0]      WB_addr_M_i,
  input  logic [31:0]      WB_alu_M_i,
  input  logic [31:0]      WB_mem_M_i,
  input  logic             WB_stall_W_i,
  input  logic             WB_flush_W_i,
  output logic [4:0]       WB_A3_W_o,
  output logic [31:0]      WB_WD3_W_o,
  output logic             WB_we3_W_o,
  output logic [31:0]      WB_npc_W_o,
  output logic [CNT_W-1:0] WB_retire_cnt_W_o
);

  m_w_t             w_q, w_d, m_in;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic [31:0]      ld_data;
  logic [29:0]      unused_addr_hi;

  assign unused_addr_hi = WB_addr_M_i[31:2];

  always_comb begin
    m_in          = '0;
    m_in.valid    = WB_valid_M_i;
    m_in.pc       = WB_pc_M_i;
    m_in.rd       = WB_rd_M_i;
    m_in.regwrite = WB_regwrite_M_i;
    m_in.wdsel    = WB_wdsel_M_i;
    m_in.ldtype   = WB_ldtype_M_i;
    m_in.addr     = WB_addr_M_i[1:0];
    m_in.alu      = WB_alu_M_i;
    m_in.mem      = WB_mem_M_i;
  end

  // A flush overwrites W with a bubble even under stall, so the
  // held instruction leaves W and counts as retired then.
  assign retire = w_q.valid &
                  (~WB_stall_W_i | WB_flush_W_i);

  always_comb begin
    w_d   = w_q;
    cnt_d = cnt_q;
    if (WB_flush_W_i) begin
      w_d.valid = 1'b0;
    end else if (!WB_stall_W_i) begin
      w_d = m_in;
    end
    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge WB_clk_W_i) begin
    if (!WB_rstn_W_i) begin
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  wb_load_ext u_ld (
    .ldtype_i (w_q.ldtype),
    .addr_i   (w_q.addr),
    .word_i   (w_q.mem),
    .data_o   (ld_data)
  );

  always_comb begin
    WB_WD3_W_o = 32'd0;
    case (wdsel_e'(w_q.wdsel))
      WD_ALU:  WB_WD3_W_o = w_q.alu;
      WD_MEM:  WB_WD3_W_o = ld_data;
      WD_PC8:  WB_WD3_W_o = pc_plus8(w_q.pc);
      default: WB_WD3_W_o = 32'd0;
    endcase
  end

  assign WB_we3_W_o = w_q.valid & w_q.regwrite &
                      (w_q.rd != 5'd0) &
                      (w_q.wdsel != WD_RSV);
  assign WB_A3_W_o  = w_q.rd;
  assign WB_npc_W_o = w_q.pc;
  assign WB_retire_cnt_W_o = cnt_q;

  logic trace_fire;
  assign trace_fire = WB_rstn_W_i & WB_we3_W_o &
                      ~WB_stall_W_i;

`ifdef GRF_WB_TRACE_EN
  always @(posedge WB_clk_W_i) begin
    if (trace_fire) begin
      $display("%0t@%h: $%0d <= %h", $time,
               WB_npc_W_o, WB_A3_W_o, WB_WD3_W_o);
    end
  end
`else
  logic unused_trace;
  assign unused_trace = trace_fire;
`endif

endmodule

// File: tb/tb_grf_wb_driver.sv
// Directed + random bench for grf_wb_driver (CNT_W=4).
// Reference model tracks W contents and retire count arithmetically.
module tb_grf_wb_driver;

  logic        clk = 1'b0;
  logic        rstn;
  logic        v;
  logic [31:0] pc;
  logic [4:0]  rd;
  logic        rw;
  logic [1:0]  ws;
  logic [2:0]  lt;
  logic [31:0] addr;
  logic [31:0] alu;
  logic [31:0] mem;
  logic        stall;
  logic        flush;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        we3;
  logic [31:0] npc;
  logic [3:0]  cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          mv;
  bit [31:0]   mpc;
  bit [4:0]    mrd;
  bit          mrw;
  int          mws;
  int          mlt;
  int          maddr;
  bit [31:0]   malu;
  bit [31:0]   mmem;
  int          mcnt;

  always #5 clk = ~clk;

  grf_wb_driver #(.CNT_W(4)) dut (
    .WB_clk_W_i        (clk),
    .WB_rstn_W_i       (rstn),
    .WB_valid_M_i      (v),
    .WB_pc_M_i         (pc),
    .WB_rd_M_i         (rd),
    .WB_regwrite_M_i   (rw),
    .WB_wdsel_M_i      (ws),
    .WB_ldtype_M_i     (lt),
    .WB_addr_M_i       (addr),
    .WB_alu_M_i        (alu),
    .WB_mem_M_i        (mem),
    .WB_stall_W_i      (stall),
    .WB_flush_W_i      (flush),
    .WB_A3_W_o         (a3),
    .WB_WD3_W_o        (wd3),
    .WB_we3_W_o        (we3),
    .WB_npc_W_o        (npc),
    .WB_retire_cnt_W_o (cnt)
  );

  function automatic bit [31:0] m_load();
    bit [31:0] byt;
    bit [31:0] hw;
    byt = (mmem >> (8 * maddr)) & 32'hFF;
    hw  = (mmem >> (16 * (maddr / 2))) & 32'hFFFF;
    case (mlt)
      1: return (byt >= 128) ? byt - 256 : byt;
      2: return byt;
      3: return (hw >= 32768) ? hw - 65536 : hw;
      4: return hw;
      default: return mmem;
    endcase
  endfunction

  function automatic bit [31:0] m_wd();
    case (mws)
      0: return malu;
      1: return m_load();
      2: return mpc + 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_we();
    return mv && mrw && mrd != 0 && mws != 3;
  endfunction

  task automatic step();
    if (!rstn) begin
      mv = 0; mpc = 0; mrd = 0; mrw = 0; mws = 0;
      mlt = 0; maddr = 0; malu = 0; mmem = 0;
      mcnt = 0;
    end else begin
      if (mv && (!stall || flush)) mcnt = (mcnt + 1) % 16;
      if (flush) mv = 0;
      else if (!stall) begin
        mv = v; mpc = pc; mrd = rd; mrw = rw;
        mws = ws; mlt = lt; maddr = addr % 4;
        malu = alu; mmem = mem;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".we3"}, {31'd0, we3}, {31'd0, m_we()});
    chk({tag, ".cnt"}, {28'd0, cnt}, mcnt);
    if (mv) begin
      chk({tag, ".a3"}, {27'd0, a3}, {27'd0, mrd});
      chk({tag, ".npc"}, npc, mpc);
      chk({tag, ".wd3"}, wd3, m_wd());
    end
  endtask

  task automatic drive(input bit vv, input bit [31:0] p,
                       input bit [4:0] r, input bit w,
                       input bit [1:0] s, input bit [2:0] l,
                       input bit [31:0] a, input bit [31:0] al,
                       input bit [31:0] m);
    v = vv; pc = p; rd = r; rw = w; ws = s; lt = l;
    addr = a; alu = al; mem = m;
  endtask

  initial begin
    rstn = 0; stall = 0; flush = 0;
    drive(1, 32'h100, 5'd3, 1, 2'd0, 3'd0, 0, 32'hDEAD, 0);
    stall = 1; flush = 1;
    step();
    step();
    chk("rst.we3", {31'd0, we3}, 0);
    chk("rst.a3", {27'd0, a3}, 0);
    chk("rst.npc", npc, 0);
    chk("rst.wd3", wd3, 0);
    chk("rst.cnt", {28'd0, cnt}, 0);
    rstn = 1; stall = 0; flush = 0;

    drive(1, 32'h1000, 5'd5, 1, 2'd1, 3'd1, 32'h3,
          32'h0, 32'h80FF7F01);
    step();
    chk("lb.wd3", wd3, 32'hFFFFFF80);
    chk("lb.a3", {27'd0, a3}, 32'd5);
    chk("lb.we3", {31'd0, we3}, 1);
    chk_all("lb");

    drive(1, 32'h1004, 5'd6, 1, 2'd1, 3'd4, 32'h2,
          32'h0, 32'h80FF7F01);
    step();
    chk("lhu.wd3", wd3, 32'h000080FF);
    chk_all("lhu");
    drive(1, 32'h1008, 5'd7, 1, 2'd1, 3'd3, 32'h2,
          32'h0, 32'h80FF7F01);
    step();
    chk("lh.wd3", wd3, 32'hFFFF80FF);
    chk_all("lh");

    drive(1, 32'h3000, 5'd31, 1, 2'd2, 3'd0, 0, 32'h5, 0);
    step();
    chk("jal.wd3", wd3, 32'h00003008);
    chk("jal.we3", {31'd0, we3}, 1);
    chk_all("jal");
    drive(1, 32'h3000, 5'd0, 1, 2'd2, 3'd0, 0, 32'h5, 0);
    step();
    chk("jal0.we3", {31'd0, we3}, 0);
    chk_all("jal0");

    drive(1, 32'h2000, 5'd9, 1, 2'd0, 3'd0, 0, 32'h1234, 0);
    step();
    chk_all("pre_stall");
    drive(1, 32'h2004, 5'd10, 1, 2'd0, 3'd0, 0, 32'h9999, 0);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.wd3", wd3, 32'h1234);
      chk_all("stall");
    end
    flush = 1;
    step();
    chk("sflush.we3", {31'd0, we3}, 0);
    chk_all("sflush");
    stall = 0; flush = 0;

    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom,
            $urandom_range(0, 1), $urandom, $urandom,
            $urandom, $urandom, $urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      step();
      chk_all("rand");
    end
    stall = 0; flush = 0;

    rstn = 0;
    step();
    rstn = 1;
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'h4000 + 4 * i, 5'd1, 1, 2'd0, 3'd0,
            0, i, 0);
      step();
    end
    v = 0;
    step();
    chk("wrap.cnt", {28'd0, cnt}, 0);
    chk_all("wrap");

    drive(1, 32'h5000, 5'd12, 1, 2'd0, 3'd0, 0, 32'h77, 0);
    step();
    chk_all("mid_cap");
    stall = 1;
    step();
    chk_all("mid_stall");
    rstn = 0;
    step();
    chk("midrst.we3", {31'd0, we3}, 0);
    chk("midrst.cnt", {28'd0, cnt}, 0);
    chk_all("midrst");
    rstn = 1; stall = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_wb_driver.md
GRF_WB_DRIVER -- requirements
Module: grf_wb_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-002 SHALL have port WB_clk_W_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port WB_rstn_W_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port WB_valid_M_i, input, 1 bit: the M-stage slot holds a live instruction.
REQ-005 SHALL have port WB_pc_M_i, input, 32 bits: PC of the M-stage instruction.
REQ-006 SHALL have port WB_rd_M_i, input, 5 bits: destination register index.
REQ-007 SHALL have port WB_regwrite_M_i, input, 1 bit: the instruction writes the GRF.
REQ-008 SHALL have port WB_wdsel_M_i, input, 2 bits: write-data source (ALU / MEM / PC+8 / reserved).
REQ-009 SHALL have port WB_ldtype_M_i, input, 3 bits: load type (LW / LB / LBU / LH / LHU).
REQ-010 SHALL have port WB_addr_M_i, input, 32 bits: memory address; only bits [1:0] are used.
REQ-011 SHALL have port WB_alu_M_i, input, 32 bits: ALU result.
REQ-012 SHALL have port WB_mem_M_i, input, 32 bits: raw memory word.
REQ-013 SHALL have port WB_stall_W_i, input, 1 bit: hold the W register.
REQ-014 SHALL have port WB_flush_W_i, input, 1 bit: load a bubble into the W register.
REQ-015 SHALL have port WB_A3_W_o, output, 5 bits: GRF write address.
REQ-016 SHALL have port WB_WD3_W_o, output, 32 bits: GRF write data.
REQ-017 SHALL have port WB_we3_W_o, output, 1 bit: GRF write enable.
REQ-018 SHALL have port WB_npc_W_o, output, 32 bits: PC forwarded to the GRF write trace.
REQ-019 SHALL have port WB_retire_cnt_W_o, output, CNT_W bits: count of retired instructions.

Function
REQ-020 SHALL update the W register on each rising edge with priority reset > flush > stall > capture; capture copies all M inputs.
REQ-021 SHALL, on flush, clear W valid and keep the other fields don't-care; flush SHALL win over a simultaneous stall.
REQ-022 SHALL, on stall without flush, hold every W field unchanged.
REQ-023 SHALL drive we3 = Wvalid AND Wregwrite AND (Wrd != 0) AND (Wwdsel != 3), combinationally from the W register.
REQ-024 SHALL drive A3 = Wrd and npc = Wpc directly from the W register; all outputs SHALL settle one cycle after capture.
REQ-025 SHALL select WD3 by wdsel: 0 gives alu; 1 gives the load-extended mem word; 2 gives pc+8 (mod 2^32); 3 gives 0.
REQ-026 SHALL perform little-endian load extension:
  - LW: the whole word; addr[1:0] ignored.
  - LB / LBU: byte addr[1:0], sign- or zero-extended.
  - LH / LHU: half addr[1], sign- or zero-extended; addr[0] ignored.
  - Undefined ldtype: behaves as LW.
REQ-027 SHALL increment the retire counter at each rising edge where Wvalid=1 and stall=0, wrapping from 2^CNT_W-1 to 0.
REQ-028 SHALL count the W instruction as retired when flush coincides with Wvalid=1 and stall=0; flush only kills the incoming M instruction.
REQ-029 SHALL let a stalled W instruction with we3=1 rewrite the same value every cycle; this is idempotent and SHALL NOT increment the counter.

Reset
REQ-030 SHALL, while WB_rstn_W_i=0 at a rising edge, clear Wvalid, Wrd, Wpc, Wregwrite, Wwdsel and the retire counter to 0, overriding flush, stall and capture.
REQ-031 SHALL give the following output values after reset: we3=0, A3=0, npc=0, WD3=0 (Walu cleared), retire_cnt=0.
REQ-032 SHALL, on reset asserted mid-stall, discard the held instruction with no write and no count.

Configuration
REQ-033 SHALL, when macro GRF_WB_TRACE_EN is defined, print "<time>@<pc hex>: $<rd dec> <= <data hex>" on every rising edge where we3=1 and stall=0.
REQ-034 SHALL, without GRF_WB_TRACE_EN, contain no simulation-only statements; datapath behaviour SHALL be identical either way.

Structure
REQ-035 SHALL take the wdsel encodings (ALU=0, MEM=1, PC8=2) and ldtype encodings (LW=0, LB=1, LBU=2, LH=3, LHU=4) from the shared package cpu_pkg.
REQ-036 SHALL place load extension in a combinational sub-module wb_load_ext (inputs ldtype, addr[1:0], word; output 32-bit data).

Verification
REQ-037 SHALL cover LB: mem=0x80FF7F01, addr[1:0]=3, rd=5, wdsel=MEM, valid=1 -> next cycle we3=1, A3=5, WD3=0xFFFFFF80.
REQ-038 SHALL cover LHU and LH: mem=0x80FF7F01, addr[1:0]=2, LHU -> WD3=0x000080FF; same with LH -> WD3=0xFFFF80FF.
REQ-039 SHALL cover JAL-style writeback: pc=0x00003000, wdsel=PC8, rd=31 -> WD3=0x00003008, we3=1; same with rd=0 -> we3=0.
REQ-040 SHALL cover stall then flush: stall=1 for 3 cycles -> outputs held and counter unchanged; stall=1 with flush=1 -> next cycle we3=0 and counter +1.
REQ-041 SHALL cover counter wrap: CNT_W=4, 16 valid unstalled instructions from reset -> retire_cnt returns to 0.
REQ-042 SHALL cover mid-operation reset: rstn=0 during a stall with valid W -> next cycle we3=0, retire_cnt=0, no trace line.
